// File: rtl/pn_seq_arbiter_if.sv
// Request/stream bundle for pn_seq_arbiter: four burst requesters in, one PN bit stream out.
// The master modport is the arbiter; the slave modport is the requester/sink environment.
interface pn_seq_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int LEN_W   = 3
);
    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int SEED_W = 3;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*SEED_W-1:0] req_seed;
    logic [NUM_REQ*LEN_W-1:0]  req_len;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      m_tvalid;
    logic                      m_tready;
    logic                      m_tdata;
    logic [SEED_W-1:0]         m_tstate;
    logic                      m_tlast;
    logic [ID_W-1:0]           m_tid;

    modport master (
        input  req_valid, req_seed, req_len, m_tready,
        output req_ready, m_tvalid, m_tdata, m_tstate, m_tlast, m_tid
    );

    modport slave (
        output req_valid, req_seed, req_len, m_tready,
        input  req_ready, m_tvalid, m_tdata, m_tstate, m_tlast, m_tid
    );
endinterface

// File: rtl/pn_seq_arbiter.sv
// Round-robin arbiter that grants one requester at a time a burst of len+1 bits
// from a 3-bit LFSR seeded by that requester, streamed with valid/ready.
module pn_seq_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int LEN_W   = 3
) (
    input  logic              clk,
    input  logic              reset,
    pn_seq_arbiter_if.master  bus,
    output logic              busy
);
    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int SEED_W = 3;

    typedef enum logic {IDLE, STREAM} state_e;

    state_e             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [SEED_W-1:0]  lfsr_q, lfsr_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [ID_W-1:0]    id_q, id_d;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    win;
    logic [ID_W-1:0]    idx;
    logic               found;
    logic [SEED_W-1:0]  seed;
    logic               last;

    // Rotating priority search starting at ptr; the 2-bit index wraps modulo 4 for free.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch is inferred.
        grant = '0;
        win   = ptr_q;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ptr_q + k[ID_W-1:0];
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        if (found) grant[win] = 1'b1;
    end

    assign seed = bus.req_seed[int'(win)*SEED_W +: SEED_W];
    assign last = (cnt_q == len_q);

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        lfsr_d        = lfsr_q;
        cnt_d         = cnt_q;
        len_d         = len_q;
        id_d          = id_q;
        bus.req_ready = '0;
        bus.m_tvalid  = 1'b0;
        bus.m_tdata   = 1'b0;
        bus.m_tstate  = '0;
        bus.m_tlast   = 1'b0;
        bus.m_tid     = id_q;
        busy          = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Grant is masked during reset so no requester sees ready while held.
                if (reset) bus.req_ready = grant;
                if (found) begin
                    lfsr_d  = (seed == '0) ? SEED_W'(1) : seed;
                    len_d   = bus.req_len[int'(win)*LEN_W +: LEN_W];
                    id_d    = win;
                    cnt_d   = '0;
                    ptr_d   = win + ID_W'(1);
                    state_d = STREAM;
                end
            end
            STREAM: begin
                busy         = 1'b1;
                bus.m_tvalid = 1'b1;
                bus.m_tdata  = lfsr_q[0];
                bus.m_tstate = lfsr_q;
                bus.m_tlast  = last;
                if (bus.m_tready) begin
                    lfsr_d = {lfsr_q[2] ^ lfsr_q[0], lfsr_q[2:1]};
                    cnt_d  = cnt_q + LEN_W'(1);
                    if (last) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            lfsr_q  <= SEED_W'(1);
            cnt_q   <= '0;
            len_q   <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            id_q    <= id_d;
        end
    end
endmodule

// File: tb/tb_pn_seq_arbiter.sv
// Directed bench for pn_seq_arbiter: stimulus pushes expected beats into a queue,
// a negedge monitor pops and compares every accepted output beat.
module tb_pn_seq_arbiter;
    typedef struct packed {
        logic [1:0] tid;
        logic       tlast;
        logic [2:0] tstate;
        logic       tdata;
    } beat_t;

    logic  clk = 1'b0;
    logic  reset;
    logic  busy;
    beat_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;

    pn_seq_arbiter_if bus ();

    pn_seq_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] lfsr_next(input logic [2:0] s);
        return {s[2] ^ s[0], s[2:1]};
    endfunction

    task automatic push_burst(input logic [2:0] seed, input int len, input logic [1:0] id);
        logic [2:0] s;
        s = (seed == 3'b000) ? 3'b001 : seed;
        for (int b = 0; b <= len; b++) begin
            exp_q.push_back(beat_t'({id, (b == len), s, s[0]}));
            s = lfsr_next(s);
        end
    endtask

    task automatic push_beat(input logic [1:0] id, input logic tlast, input logic [2:0] st, input logic dt);
        exp_q.push_back(beat_t'({id, tlast, st, dt}));
    endtask

    task automatic set_req(input int i, input logic [2:0] seed, input logic [2:0] len);
        bus.req_seed[i*3 +: 3] = seed;
        bus.req_len[i*3 +: 3]  = len;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted beat must match the head of the expected queue.
    always @(negedge clk) begin
        if (reset && bus.m_tvalid && bus.m_tready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {25'd0, bus.m_tid, bus.m_tlast, bus.m_tstate, bus.m_tdata}, 32'hFFFF_FFFF);
            end else begin
                check("beat", {25'd0, bus.m_tid, bus.m_tlast, bus.m_tstate, bus.m_tdata}, {25'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rr_len [4];
        logic [2:0] st_tab [7];
        logic       dt_tab [7];
        int id;
        rr_len = '{1, 2, 0, 3};
        st_tab = '{3'b001, 3'b100, 3'b110, 3'b111, 3'b011, 3'b101, 3'b010};
        dt_tab = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

        reset         = 1'b0;
        bus.req_valid = '0;
        bus.req_seed  = '0;
        bus.req_len   = '0;
        bus.m_tready  = 1'b0;
        repeat (3) tick();

        // Reset state, with all requesters asserting.
        set_req(0, 3'd1, 3'd1);
        set_req(1, 3'd2, 3'd2);
        set_req(2, 3'd3, 3'd0);
        set_req(3, 3'd4, 3'd3);
        bus.req_valid = 4'b1111;
        #1;
        check("rst_req_ready", bus.req_ready, 4'b0000);
        check("rst_outputs", {bus.m_tvalid, bus.m_tlast, bus.m_tdata, bus.m_tstate, bus.m_tid, busy}, 0);
        tick();
        reset        = 1'b1;
        bus.m_tready = 1'b1;

        // Round-robin with 1111 held: grants 0,1,2,3,0, one idle cycle between bursts.
        push_burst(3'd1, 1, 2'd0);
        push_burst(3'd2, 2, 2'd1);
        push_burst(3'd3, 0, 2'd2);
        push_burst(3'd4, 3, 2'd3);
        push_burst(3'd1, 1, 2'd0);
        for (int g = 0; g < 5; g++) begin
            id = g % 4;
            #1;
            check("rr_grant", bus.req_ready, 32'(1) << id);
            check("rr_idle_gap", bus.m_tvalid, 0);
            tick();
            if (g == 4) bus.req_valid = 4'b0000;
            check("rr_first_valid", bus.m_tvalid, 1);
            check("rr_tid", bus.m_tid, id);
            repeat (rr_len[id] + 1) tick();
        end

        // Single burst, seed 001, len 6.
        set_req(0, 3'b001, 3'd6);
        bus.req_valid = 4'b0001;
        for (int b = 0; b < 7; b++) push_beat(2'd0, (b == 6), st_tab[b], dt_tab[b]);
        #1;
        check("single_grant", bus.req_ready, 4'b0001);
        tick();
        bus.req_valid = 4'b0000;
        check("single_busy", busy, 1);
        repeat (7) tick();
        check("single_idle", {bus.m_tvalid, busy, bus.m_tlast, bus.m_tdata, bus.m_tstate}, 0);
        check("single_tid_hold", bus.m_tid, 0);

        // Zero seed loads as 001.
        set_req(2, 3'b000, 3'd1);
        bus.req_valid = 4'b0100;
        push_beat(2'd2, 1'b0, 3'b001, 1'b1);
        push_beat(2'd2, 1'b1, 3'b100, 1'b0);
        tick();
        bus.req_valid = 4'b0000;
        check("zseed_state", bus.m_tstate, 3'b001);
        repeat (2) tick();
        check("zseed_idle", bus.m_tvalid, 0);
        check("zseed_tid_hold", bus.m_tid, 2);

        // Backpressure: ready 1,0,0,1 holds beat 2 for three cycles.
        set_req(1, 3'b001, 3'd3);
        bus.req_valid = 4'b0010;
        push_beat(2'd1, 1'b0, 3'b001, 1'b1);
        push_beat(2'd1, 1'b0, 3'b100, 1'b0);
        push_beat(2'd1, 1'b0, 3'b110, 1'b0);
        push_beat(2'd1, 1'b1, 3'b111, 1'b1);
        tick();
        bus.req_valid = 4'b0000;
        tick();
        bus.m_tready = 1'b0;
        #1;
        check("bp_hold0", {bus.m_tvalid, bus.m_tstate}, 4'b1100);
        tick();
        check("bp_hold1", {bus.m_tvalid, bus.m_tstate}, 4'b1100);
        tick();
        check("bp_hold2", {bus.m_tvalid, bus.m_tstate}, 4'b1100);
        bus.m_tready = 1'b1;
        repeat (3) tick();
        check("bp_idle", bus.m_tvalid, 0);

        // Minimum length: one beat carrying tlast.
        set_req(3, 3'd5, 3'd0);
        bus.req_valid = 4'b1000;
        push_burst(3'd5, 0, 2'd3);
        tick();
        bus.req_valid = 4'b0000;
        check("len0_tlast", {bus.m_tvalid, bus.m_tlast}, 2'b11);
        tick();
        check("len0_idle", bus.m_tvalid, 0);

        // Maximum length: eight beats, tlast only on the eighth.
        set_req(0, 3'd3, 3'd7);
        bus.req_valid = 4'b0001;
        push_burst(3'd3, 7, 2'd0);
        tick();
        bus.req_valid = 4'b0000;
        repeat (7) tick();
        check("len7_tlast", {bus.m_tvalid, bus.m_tlast}, 2'b11);
        tick();
        check("len7_idle", bus.m_tvalid, 0);

        // Reset mid-burst at beat 3, then restart with ptr back at 0.
        set_req(2, 3'b001, 3'd6);
        bus.req_valid = 4'b0100;
        push_burst(3'b001, 6, 2'd2);
        tick();
        bus.req_valid = 4'b0000;
        repeat (2) tick();
        check("abort_beat3", {bus.m_tvalid, bus.m_tstate}, 4'b1110);
        reset = 1'b0;
        #1;
        check("abort_async", {bus.m_tvalid, busy, bus.m_tlast}, 0);
        exp_q.delete();
        set_req(1, 3'b001, 3'd6);
        set_req(3, 3'd2, 3'd2);
        bus.req_valid = 4'b1010;
        #1;
        check("abort_rst_ready", bus.req_ready, 4'b0000);
        tick();
        reset = 1'b1;
        push_burst(3'b001, 6, 2'd1);
        #1;
        check("ptr_after_reset", bus.req_ready, 4'b0010);
        tick();
        bus.req_valid = 4'b0000;
        check("restart_seed", {bus.m_tvalid, bus.m_tstate, bus.m_tid}, {1'b1, 3'b001, 2'd1});
        repeat (7) tick();
        check("restart_idle", bus.m_tvalid, 0);

        repeat (2) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
